// File: rtl/axis_pkt_fifo_32_pkg.sv
// Shared types for the 32-bit store-and-forward AXI4-Stream packet FIFO.
// Beat layout and write-side FSM states.
package axis_pkt_fifo_32_pkg;

  localparam int AXIS_DATA_BITS = 32;
  localparam int AXIS_KEEP_BITS = 4;

  typedef struct packed {
    logic [AXIS_DATA_BITS-1:0] tdata;
    logic [AXIS_KEEP_BITS-1:0] tkeep;
    logic                      tlast;
  } beat_t;

  typedef enum logic {
    ST_PASS,
    ST_DROP
  } wr_state_t;

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Beat storage for the packet FIFO: one write port, combinational read.
// Contents are never reset; the pointers decide what is valid.
module axis_pkt_fifo_ram
  import axis_pkt_fifo_32_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int BW    = $bits(beat_t)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo_32.sv
// Store-and-forward packet FIFO for 32-bit AXI4-Stream.
// Releases only complete packets; oversize packets are dropped whole.
module axis_pkt_fifo_32
  import axis_pkt_fifo_32_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [31:0]   s_axis_tdata,
  input  logic [3:0]    s_axis_tkeep,
  input  logic          s_axis_tlast,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [31:0]   m_axis_tdata,
  output logic [3:0]    m_axis_tkeep,
  output logic          m_axis_tlast,
  output logic [PW-1:0] pkt_cnt,
  output logic          drop
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] cm_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] used;
  logic [PW-1:0] committed;
  logic          full;

  wr_state_t state;
  wr_state_t state_nxt;

  logic  wr_en;
  logic  commit;
  logic  rewind;
  logic  drop_end;
  logic  rd_hs;
  logic  rd_last;
  beat_t wr_beat;
  beat_t rd_beat;

  assign used      = wr_ptr - rd_ptr;
  assign committed = cm_ptr - rd_ptr;
  assign full      = (used == PW'(DEPTH));

  assign wr_beat = '{
    tdata: s_axis_tdata,
    tkeep: s_axis_tkeep,
    tlast: s_axis_tlast
  };

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b1;
    wr_en         = 1'b0;
    commit        = 1'b0;
    rewind        = 1'b0;
    drop_end      = 1'b0;
    unique case (state)
      ST_PASS: begin
        s_axis_tready = !full;
        wr_en         = s_axis_tvalid && !full;
        commit        = wr_en && s_axis_tlast;
        // buffer is full of one unterminated packet
        if (full && committed == '0) begin
          state_nxt = ST_DROP;
          rewind    = 1'b1;
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = ST_PASS;
          drop_end  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign m_axis_tvalid = (committed != '0);
  assign m_axis_tdata  = rd_beat.tdata;
  assign m_axis_tkeep  = rd_beat.tkeep;
  assign m_axis_tlast  = rd_beat.tlast;
  assign rd_hs         = m_axis_tvalid && m_axis_tready;
  assign rd_last       = rd_hs && rd_beat.tlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= ST_PASS;
      wr_ptr  <= '0;
      cm_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
      drop    <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_end;
      if (rewind) wr_ptr <= cm_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) cm_ptr <= wr_ptr + 1'b1;
      if (rd_hs) rd_ptr <= rd_ptr + 1'b1;
      unique case ({commit, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  axis_pkt_fifo_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (aclk),
    .we   (wr_en),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wr_beat),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_beat)
  );

endmodule

// File: tb/tb_axis_pkt_fifo_32.sv
// Bench for axis_pkt_fifo_32: queue model checked every cycle
// plus directed packet scenarios with literal expectations.
module tb_axis_pkt_fifo_32;
  import axis_pkt_fifo_32_pkg::*;

  localparam int DEPTH = 64;
  localparam int PW    = 7;

  logic          aclk;
  logic          areset;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [31:0]   s_axis_tdata;
  logic [3:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [31:0]   m_axis_tdata;
  logic [3:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic [PW-1:0] pkt_cnt;
  logic          drop;

  axis_pkt_fifo_32 #(.DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .pkt_cnt      (pkt_cnt),
    .drop         (drop)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: committed beats, the packet being assembled, drop mode
  beat_t mq[$];
  beat_t mpart[$];
  bit    mdrop_mode;
  bit    mdrop;

  function automatic int tlast_count();
    int n = 0;
    foreach (mq[i]) n += int'(mq[i].tlast);
    return n;
  endfunction

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      mq.delete();
      mpart.delete();
      mdrop_mode = 0;
      mdrop      = 0;
    end else begin
      int    qn;
      int    un;
      bit    shs;
      bit    mhs;
      beat_t b;
      qn  = mq.size();
      un  = qn + mpart.size();
      shs = s_axis_tvalid && (mdrop_mode || un < DEPTH);
      mhs = m_axis_tready && (qn != 0);
      b.tdata = s_axis_tdata;
      b.tkeep = s_axis_tkeep;
      b.tlast = s_axis_tlast;
      mdrop = 0;
      if (mhs) void'(mq.pop_front());
      if (!mdrop_mode) begin
        if (un == DEPTH && qn == 0) begin
          mpart.delete();
          mdrop_mode = 1;
        end else if (shs) begin
          mpart.push_back(b);
          if (b.tlast) begin
            foreach (mpart[i]) mq.push_back(mpart[i]);
            mpart.delete();
          end
        end
      end else if (shs && b.tlast) begin
        mdrop_mode = 0;
        mdrop      = 1;
      end
    end
  end

  always @(negedge aclk) begin
    if (!areset) begin
      bit ev;
      ev = (mq.size() != 0);
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(ev));
      chk("s_tready", 64'(s_axis_tready),
          64'(mdrop_mode || (mq.size() + mpart.size()) < DEPTH));
      chk("pkt_cnt", 64'(pkt_cnt), 64'(tlast_count()));
      chk("drop", 64'(drop), 64'(mdrop));
      if (ev && m_axis_tvalid) begin
        chk("m_tdata", 64'(m_axis_tdata), 64'(mq[0].tdata));
        chk("m_tkeep", 64'(m_axis_tkeep), 64'(mq[0].tkeep));
        chk("m_tlast", 64'(m_axis_tlast), 64'(mq[0].tlast));
      end
    end
  end

  // observed output beats and drop pulses
  beat_t olog[$];
  int    n_drop_seen = 0;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      olog.delete();
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        beat_t o;
        o.tdata = m_axis_tdata;
        o.tkeep = m_axis_tkeep;
        o.tlast = m_axis_tlast;
        olog.push_back(o);
      end
      if (drop) n_drop_seen++;
    end
  end

  int sink_mode = 1;

  always @(negedge aclk) begin
    case (sink_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic l, input int gap);
    logic done;
    done = 1'b0;
    repeat (gap) begin
      s_axis_tvalid = 1'b0;
      @(negedge aclk);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    for (int t = 0; t < 2000 && !done; t++) begin
      bit hs;
      hs = s_axis_tready;
      @(negedge aclk);
      if (hs) done = 1'b1;
    end
    s_axis_tvalid = 1'b0;
    if (!done) chk("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic send_pkt(input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++)
      send_beat(base + 32'(i), 4'hF, i == len - 1, 0);
  endtask

  int total;
  int bad;
  int drops0;
  logic [31:0] exp7 [7];

  initial begin
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    wait_cycles(3);
    areset = 1'b0;
    wait_cycles(1);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);

    // 3-beat packet, sink always ready
    olog.delete();
    sink_mode = 1;
    wait_cycles(2);
    send_beat(32'hA, 4'hF, 1'b0, 0);
    chk("t1_tvalid_a", 64'(m_axis_tvalid), 64'd0);
    send_beat(32'hB, 4'hF, 1'b0, 0);
    chk("t1_tvalid_b", 64'(m_axis_tvalid), 64'd0);
    send_beat(32'hC, 4'hF, 1'b1, 0);
    chk("t1_tvalid_c", 64'(m_axis_tvalid), 64'd1);
    chk("t1_pkt_cnt1", 64'(pkt_cnt), 64'd1);
    wait_cycles(6);
    chk("t1_count", 64'(olog.size()), 64'd3);
    chk("t1_d0", 64'(olog[0].tdata), 64'hA);
    chk("t1_d1", 64'(olog[1].tdata), 64'hB);
    chk("t1_d2", 64'(olog[2].tdata), 64'hC);
    chk("t1_last", 64'({olog[0].tlast, olog[1].tlast, olog[2].tlast}),
        64'b001);
    chk("t1_pkt_cnt0", 64'(pkt_cnt), 64'd0);

    // 2- and 5-beat packets held, then released
    olog.delete();
    sink_mode = 0;
    wait_cycles(2);
    send_pkt(32'h20, 2);
    send_pkt(32'h50, 5);
    wait_cycles(1);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);
    chk("t2_tready", 64'(s_axis_tready), 64'd1);
    sink_mode = 1;
    wait_cycles(12);
    exp7 = '{32'h20, 32'h21, 32'h50, 32'h51, 32'h52, 32'h53, 32'h54};
    chk("t2_count", 64'(olog.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      chk("t2_data", 64'(olog[i].tdata), 64'(exp7[i]));
      chk("t2_last", 64'(olog[i].tlast), 64'(i == 1 || i == 6));
    end

    // 70-beat oversize packet is dropped whole
    olog.delete();
    drops0 = n_drop_seen;
    for (int i = 0; i < 70; i++) begin
      send_beat(32'h3000 + 32'(i), 4'hF, i == 69, 0);
      if (i == 63) chk("t3_full_tready", 64'(s_axis_tready), 64'd0);
      if (i >= 64 && i < 69)
        chk("t3_drop_tready", 64'(s_axis_tready), 64'd1);
    end
    chk("t3_drop_pulse", 64'(drop), 64'd1);
    wait_cycles(1);
    chk("t3_drop_end", 64'(drop), 64'd0);
    chk("t3_drop_once", 64'(n_drop_seen - drops0), 64'd1);
    chk("t3_no_output", 64'(olog.size()), 64'd0);
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd0);
    send_pkt(32'h40, 2);
    wait_cycles(5);
    chk("t3_after_count", 64'(olog.size()), 64'd2);
    chk("t3_after_d0", 64'(olog[0].tdata), 64'h40);
    chk("t3_after_d1", 64'(olog[1].tdata), 64'h41);
    chk("t3_after_last", 64'(olog[1].tlast), 64'd1);

    // exact-fit 64-beat packet
    olog.delete();
    drops0 = n_drop_seen;
    sink_mode = 0;
    wait_cycles(2);
    send_pkt(32'h5000, 64);
    chk("t4_tready_full", 64'(s_axis_tready), 64'd0);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("t4_drop", 64'(drop), 64'd0);
    sink_mode = 1;
    wait_cycles(70);
    chk("t4_count", 64'(olog.size()), 64'd64);
    bad = 0;
    foreach (olog[i])
      if (olog[i].tdata != 32'h5000 + 32'(i) ||
          olog[i].tlast != (i == 63)) bad++;
    chk("t4_order", 64'(bad), 64'd0);
    chk("t4_no_drop", 64'(n_drop_seen - drops0), 64'd0);

    // random traffic, 1000 packets of 1..40 beats
    olog.delete();
    sink_mode = 2;
    total = 0;
    for (int p = 0; p < 1000; p++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        send_beat(32'h10000 + 32'(total), 4'($urandom_range(0, 15)),
                  i == len - 1, int'($urandom_range(0, 3) == 0));
        total++;
      end
    end
    sink_mode = 1;
    wait_cycles(200);
    chk("t5_count", 64'(olog.size()), 64'(total));
    bad = 0;
    foreach (olog[i])
      if (olog[i].tdata != 32'h10000 + 32'(i)) bad++;
    chk("t5_order", 64'(bad), 64'd0);
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd0);

    // reset after 3 beats of a 10-beat packet
    olog.delete();
    for (int i = 0; i < 3; i++)
      send_beat(32'h6000 + 32'(i), 4'hF, 1'b0, 0);
    #2 areset = 1'b1;
    #1;
    chk("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t6_tready", 64'(s_axis_tready), 64'd1);
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t6_drop", 64'(drop), 64'd0);
    @(negedge aclk);
    areset = 1'b0;
    wait_cycles(1);
    send_pkt(32'h7000, 4);
    wait_cycles(8);
    chk("t6_count", 64'(olog.size()), 64'd4);
    bad = 0;
    foreach (olog[i])
      if (olog[i].tdata != 32'h7000 + 32'(i) ||
          olog[i].tlast != (i == 3)) bad++;
    chk("t6_order", 64'(bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pkt_fifo_32.md
# axis_pkt_fifo_32

Store-and-forward packet FIFO for 32-bit AXI4-Stream, placed directly upstream of the static 32-bit register slice. A packet is held back until its tlast beat is stored, so the downstream slice only ever sees gap-free packets. Packets longer than the buffer are discarded in full, with a one-cycle drop indication.

## Interface
- DEPTH, 64: buffer depth in 32-bit beats; power of two, ≥ 4.
- aclk  in  1  clock; all logic on its rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis  AXI4S.s  32/4/1  input stream (tvalid, tready, tdata[31:0], tkeep[3:0], tlast).
- m_axis  AXI4S.m  32/4/1  output stream to the register slice.
- pkt_cnt  out  $clog2(DEPTH)+1  number of complete packets currently stored.
- drop  out  1  one-cycle pulse: an oversize packet was discarded.

## Operation
- Storage: DEPTH-entry array of {tdata, tkeep, tlast}, with combinational read at rd_ptr.
- Pointers: wr_ptr, cm_ptr (one past the last stored tlast beat) and rd_ptr, each $clog2(DEPTH)+1 bits with a wrap bit.
  - used = wr_ptr − rd_ptr.
  - committed = cm_ptr − rd_ptr.
  - full = (used == DEPTH).
- Write FSM, two states:
  - ST_PASS:
    - s_axis.tready = !full.
    - On a handshake, write the beat at wr_ptr and increment wr_ptr.
    - If the beat has tlast, also set cm_ptr ← wr_ptr+1 and increment pkt_cnt.
  - ST_PASS → ST_DROP when full && committed == 0, i.e. one packet fills the whole buffer without tlast. On that edge, wr_ptr ← cm_ptr, discarding the partial packet.
  - ST_DROP:
    - s_axis.tready = 1.
    - Beats are accepted and discarded.
    - On the tlast handshake, return to ST_PASS and pulse drop in the next cycle.
  - If the DEPTH-th beat carries tlast, it commits normally and there is no drop.
- Read side:
  - m_axis.tvalid = (committed != 0).
  - m_axis.tdata/tkeep/tlast come from the entry at rd_ptr.
  - On a handshake, increment rd_ptr.
  - If the beat has tlast, decrement pkt_cnt.
- Simultaneous events:
  - Write, read and commit may all happen in one cycle.
  - pkt_cnt net change = (commit ? +1 : 0) + (read tlast ? −1 : 0).
- Full-and-draining: tready follows the registered pointers. A read in cycle N frees space only from cycle N+1; there is no same-cycle pass-through.
- Reset mid-packet:
  - All pointers, pkt_cnt and the state are cleared and all contents are discarded.
  - Upstream beats that arrive after reset release are treated as the start of a new packet.

## Timing
- Reset values:
  - m_axis.tvalid = 0, s_axis.tready = 1 (empty, ST_PASS), pkt_cnt = 0, drop = 0.
  - m_axis data fields are don't-care while tvalid = 0.
- Latency: m_axis.tvalid rises in the cycle after the edge that stores the tlast beat.
- Throughput: one beat per cycle on each side while not full and while committed beats are available.
- m_axis.tvalid never drops without a handshake, because committed beats can only decrease through reads.
- drop is high for exactly one cycle, the cycle after the ST_DROP tlast handshake.

## Structure
- Shared types package:
  - AXIS_DATA_BITS = 32, AXIS_KEEP_BITS = 4.
  - Beat struct {tdata, tkeep, tlast}.
  - Write-FSM enum {ST_PASS, ST_DROP}.
- The storage array is a sub-module, axis_pkt_fifo_ram: single write port, combinational read, with the width taken from the beat struct.
- Pointer and FSM logic stays in the top module.

## Test plan
- Single packet of 3 beats (0xA, 0xB, 0xC with tlast, tkeep = 0xF), m_axis.tready = 1:
  - m_axis.tvalid stays 0 until the cycle after the 0xC write.
  - Then 3 consecutive output beats; pkt_cnt goes 0 → 1 → 0.
- Back-to-back packets of 2 and 5 beats, m_axis.tready held low:
  - pkt_cnt = 2 and s_axis.tready = 1.
  - Release tready: 7 beats out in order, tlast on beats 2 and 7.
- Oversize, DEPTH = 64, packet of 70 beats:
  - The FSM enters ST_DROP after 64 beats and tready stays high.
  - drop pulses once after beat 70; no output beats and pkt_cnt = 0.
  - A following 2-beat packet passes intact.
- Exact fit, DEPTH = 64, packet of 64 beats with tlast:
  - No drop; all 64 beats are output; tready = 0 while full.
- Random tready/tvalid on both sides, 1000 packets of length 1–40:
  - Output equals input; pkt_cnt never exceeds the number of stored packets.
- Assert areset after beat 3 of a 10-beat packet:
  - Outputs return to reset values immediately.
  - A following 4-beat packet is emitted alone.
